// File: rtl/mem_stage_ctrl_if.sv
// Interface bundling the EX/MEM input bundle, the data-memory req/ready bus,
// the upstream stall and the registered MEM/WB bundle of mem_stage_ctrl.
interface mem_stage_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             REG_WRITE_M;
    logic             MEM_TO_REG_M;
    logic             MEM_WRITE_M;
    logic [WIDTH-1:0] ALU_OUT_M;
    logic [WIDTH-1:0] WRITE_DATA_M;
    logic [4:0]       WRITE_REG_M;

    logic             STALL_M;

    logic             DMEM_REQ;
    logic             DMEM_WE;
    logic [WIDTH-1:0] DMEM_ADDR;
    logic [WIDTH-1:0] DMEM_WDATA;
    logic [WIDTH-1:0] DMEM_RDATA;
    logic             DMEM_READY;

    logic             REG_WRITE_W;
    logic             MEM_TO_REG_W;
    logic [WIDTH-1:0] ALU_OUT_W;
    logic [WIDTH-1:0] READ_DATA_W;
    logic [4:0]       WRITE_REG_W;
    logic             MEM_ERR;

    // Environment side: pipeline producer, data memory and writeback consumer.
    modport master (
        output REG_WRITE_M, MEM_TO_REG_M, MEM_WRITE_M, ALU_OUT_M, WRITE_DATA_M, WRITE_REG_M,
        output DMEM_RDATA, DMEM_READY,
        input  STALL_M, DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA,
        input  REG_WRITE_W, MEM_TO_REG_W, ALU_OUT_W, READ_DATA_W, WRITE_REG_W, MEM_ERR
    );

    modport slave (
        input  REG_WRITE_M, MEM_TO_REG_M, MEM_WRITE_M, ALU_OUT_M, WRITE_DATA_M, WRITE_REG_M,
        input  DMEM_RDATA, DMEM_READY,
        output STALL_M, DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA,
        output REG_WRITE_W, MEM_TO_REG_W, ALU_OUT_W, READ_DATA_W, WRITE_REG_W, MEM_ERR
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: issues loads/stores over a req/ready bus, stalls upstream while
// the access is outstanding, and registers the MEM/WB bundle. MEM_TIMEOUT_EN adds a WAIT abort.
module mem_stage_ctrl #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic             CLK,
    input logic             CLR,
    mem_stage_ctrl_if.slave bus
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state;
    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             reg_write_w;
    logic             mem_to_reg_w;
    logic [WIDTH-1:0] alu_out_w;
    logic [WIDTH-1:0] read_data_w;
    logic [4:0]       write_reg_w;

    logic mem_op;
    logic is_load;
    logic abort;

    assign mem_op  = bus.MEM_TO_REG_M | bus.MEM_WRITE_M;
    // Store wins when both flags are set.
    assign is_load = bus.MEM_TO_REG_M & ~bus.MEM_WRITE_M;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             mem_err;

    // wait_cnt holds the number of earlier unanswered WAIT cycles, so this fires on the
    // TIMEOUT_CYCLES-th one; READY in that same cycle takes precedence.
    assign abort       = (state == S_WAIT) && !bus.DMEM_READY &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.MEM_ERR = mem_err;
`else
    assign abort       = 1'b0;
    assign bus.MEM_ERR = 1'b0;
`endif

    // Reset gates the stall so the pipeline is released the moment CLR rises.
    assign bus.STALL_M = !CLR && ((state == S_IDLE) ? mem_op : (!bus.DMEM_READY && !abort));

    assign bus.DMEM_REQ     = req;
    assign bus.DMEM_WE      = we;
    assign bus.DMEM_ADDR    = addr;
    assign bus.DMEM_WDATA   = wdata;
    assign bus.REG_WRITE_W  = reg_write_w;
    assign bus.MEM_TO_REG_W = mem_to_reg_w;
    assign bus.ALU_OUT_W    = alu_out_w;
    assign bus.READ_DATA_W  = read_data_w;
    assign bus.WRITE_REG_W  = write_reg_w;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state        <= S_IDLE;
            req          <= 1'b0;
            we           <= 1'b0;
            addr         <= '0;
            wdata        <= '0;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
            alu_out_w    <= '0;
            read_data_w  <= '0;
            write_reg_w  <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt     <= '0;
            mem_err      <= 1'b0;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
            mem_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        state        <= S_WAIT;
                        req          <= 1'b1;
                        we           <= bus.MEM_WRITE_M;
                        addr         <= bus.ALU_OUT_M;
                        wdata        <= bus.WRITE_DATA_M;
                        reg_write_w  <= 1'b0;
                        mem_to_reg_w <= 1'b0;
                        alu_out_w    <= '0;
                        read_data_w  <= '0;
                        write_reg_w  <= '0;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt     <= '0;
`endif
                    end else begin
                        reg_write_w  <= bus.REG_WRITE_M;
                        mem_to_reg_w <= 1'b0;
                        alu_out_w    <= bus.ALU_OUT_M;
                        read_data_w  <= '0;
                        write_reg_w  <= bus.WRITE_REG_M;
                    end
                end
                S_WAIT: begin
                    if (bus.DMEM_READY) begin
                        state        <= S_IDLE;
                        req          <= 1'b0;
                        reg_write_w  <= bus.REG_WRITE_M;
                        mem_to_reg_w <= is_load;
                        alu_out_w    <= bus.ALU_OUT_M;
                        read_data_w  <= is_load ? bus.DMEM_RDATA : '0;
                        write_reg_w  <= bus.WRITE_REG_M;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (abort) begin
                        state   <= S_IDLE;
                        req     <= 1'b0;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
